logic_acc_unit: RTL and testbench
=================================

// Module: logic_acc_unit
// PURPOSE
//  Parametrised, registered N-bit bitwise logic unit with valid/ready handshake.
//  Pairwise mode: one result per accepted beat (F = A op B).
//  Accumulate mode: folds a burst of operands into one result, emitted on the last beat.
//  Sits in the datapath library as the sequential successor of the combinational gate blocks.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=1)
//  CNT_W  8  width of beat counter; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (first beat of a burst only in accumulate mode)
//  in_op      in   3      0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 PASS_A,7 NOT_A
//  in_mode    in   1      0 pairwise, 1 accumulate (sampled on first beat only)
//  in_last    in   1      final beat of accumulate burst (ignored in pairwise)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_f      out  WIDTH  result
//  out_count  out  CNT_W  beats folded into out_f (1 in pairwise)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, out_valid=0, out_f=0, out_count=0, acc=0, cnt=0.
//  - Beat accepted when in_valid && in_ready; out beat consumed when out_valid && out_ready.
//  - in_ready = !out_valid || out_ready in all states (comb.; no dependence on in_valid).
//  - FSM states: IDLE, ACCUM.
//  - IDLE + accepted beat, in_mode=0: out_f<=A op B, out_count<=1, out_valid<=1; stay IDLE.
//  - IDLE + accepted beat, in_mode=1: acc<=A op B, op_q<=in_op, cnt<=1.
//      in_last=1 -> result emitted as pairwise (out_f<=A op B, out_count<=1), stay IDLE.
//      in_last=0 -> go ACCUM; out_valid not raised.
//  - ACCUM + accepted beat: nxt = acc op_q in_a; in_b, in_op, in_mode ignored.
//      in_last=0 -> acc<=nxt, cnt<=sat(cnt+1).
//      in_last=1 -> out_f<=nxt, out_count<=sat(cnt+1), out_valid<=1, go IDLE.
//  - Latency: result registered; out_valid high the cycle after the accepting edge.
//  - out_valid/out_f/out_count held stable while out_valid && !out_ready.
//  - Simultaneous consume + accept producing a result: out regs reload, out_valid stays 1.
//  - Consume with no new result: out_valid<=0; out_f/out_count keep last value.
//  - cnt saturates at all-ones; never wraps to 0.
//  - NAND/NOR/XNOR/NOT_A: full-width bitwise inversion; no width growth.
//  - Reset mid-burst discards partial acc; next beat starts a fresh burst from IDLE.
//  - No X propagation: unaccepted cycles do not modify any register.
// TESTING (WIDTH=4 unless noted; out_ready=1 unless noted)
//  1 Pairwise OR A=1010 B=0101 -> next cycle out_valid=1, out_f=1111, out_count=1;
//    then AND A=1100 B=1111 back-to-back -> out_f=1100.
//  2 Accumulate OR: (A=0001,B=0010), (A=0100), (A=1000,last) -> single out_valid pulse
//    after last beat, out_f=1111, out_count=3; no out_valid on beats 1-2.
//  3 Backpressure: out_ready=0 with result 1111 pending -> in_ready=0, out_f stable 5 cycles;
//    out_ready=1 -> pending beat accepted same cycle, new result next cycle.
//  4 Op latched: AND burst (1111,1100) then A=0110 op=OR last -> out_f=0100, out_count=2.
//  5 Saturation CNT_W=2: 5-beat XOR burst of A=0001 -> out_f=0001 (1^...), out_count=3.
//  6 Reset mid-burst after 2 beats -> out_valid=0, in_ready=1 immediately; fresh
//    single-beat accumulate NOR A=0000 B=0000 last -> out_f=1111, out_count=1.

Source files
------------

// File: rtl/logic_acc_if.sv
// Valid/ready bundle for logic_acc_unit: operand beats in, folded/pairwise results out.
interface logic_acc_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_f, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_f, out_count
  );
endinterface

// File: rtl/logic_acc_unit.sv
// Registered bitwise logic unit: pairwise A op B per beat, or a burst folded into one result.
module logic_acc_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  logic_acc_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  logic             in_ready;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] pair_res;
  logic [WIDTH-1:0] fold_res;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    logic_op = a & b;
      3'd1:    logic_op = a | b;
      3'd2:    logic_op = a ^ b;
      3'd3:    logic_op = ~(a & b);
      3'd4:    logic_op = ~(a | b);
      3'd5:    logic_op = ~(a ^ b);
      3'd6:    logic_op = a;
      default: logic_op = ~a;
    endcase
  endfunction

  // Beat counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  assign accept   = bus.in_valid && in_ready;
  assign consume  = valid_q && bus.out_ready;
  assign pair_res = logic_op(bus.in_op, bus.in_a, bus.in_b);
  assign fold_res = logic_op(op_q, acc_q, bus.in_a);
  assign cnt_inc  = sat_inc(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && bus.in_mode && !bus.in_last) state_d = ACCUM;
      ACCUM:   if (accept && bus.in_last)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !valid_q || bus.out_ready;
  end

  always_comb begin
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    count_d = count_q;
    valid_d = valid_q;
    if (consume) valid_d = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        if (bus.in_mode) begin
          acc_d = pair_res;
          op_d  = bus.in_op;
          cnt_d = CNT_W'(1);
        end
        if (!bus.in_mode || bus.in_last) begin
          f_d     = pair_res;
          count_d = CNT_W'(1);
          valid_d = 1'b1;
        end
      end else if (bus.in_last) begin
        f_d     = fold_res;
        count_d = cnt_inc;
        valid_d = 1'b1;
      end else begin
        acc_d = fold_res;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_f     = f_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_logic_acc_unit.sv
// Scoreboard bench for logic_acc_unit (WIDTH=4, CNT_W=2 so counter saturation is reachable).
module tb_logic_acc_unit;
  localparam int W  = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_acc_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  logic_acc_unit #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  bit [W-1:0]  exp_f_q[$];
  bit [CW-1:0] exp_c_q[$];

  bit         in_burst = 0;
  bit [2:0]   burst_op;
  bit [W-1:0] operands[$];

  logic rnd_ready = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_bit = 1'b1;
  assign bus.out_ready = rnd_ready ? rnd_bit : ready_force;
  always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [W-1:0] ref_op(input bit [2:0] op, input bit [W-1:0] a, input bit [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  // Reference: keep the whole burst as a list and fold it only when the last beat arrives.
  task automatic emit_fold();
    bit [W-1:0] v;
    int n;
    v = operands[0];
    for (int i = 1; i < operands.size(); i++) v = ref_op(burst_op, v, operands[i]);
    n = operands.size();
    exp_f_q.push_back(v);
    exp_c_q.push_back(CW'((n > CMAX) ? CMAX : n));
    operands.delete();
    in_burst = 0;
  endtask

  task automatic model_accept(input bit [W-1:0] a, input bit [W-1:0] b, input bit [2:0] op,
                              input bit mode, input bit last);
    if (!in_burst) begin
      operands.delete();
      operands.push_back(ref_op(op, a, b));
      burst_op = op;
      if (!mode || last) emit_fold();
      else in_burst = 1;
    end else begin
      operands.push_back(a);
      if (last) emit_fold();
    end
  endtask

  task automatic send(input bit [W-1:0] a, input bit [W-1:0] b, input bit [2:0] op,
                      input bit mode, input bit last);
    int guard = 0;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_mode = mode; bus.in_last = last;
    bus.in_valid = 1'b1;
    forever begin
      #1;
      if (bus.in_ready) break;
      guard++;
      if (guard > 50) begin
        tests++; fails++;
        $display("FAIL accept_timeout: in_ready stuck at 0");
        break;
      end
      @(negedge clk);
    end
    if (guard <= 50) model_accept(a, b, op, mode, last);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_f_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_remaining", exp_f_q.size(), 0);
  endtask

  bit         prev_v = 0, prev_r = 0;
  bit [W-1:0] prev_f;
  bit [CW-1:0] prev_c;

  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_f", bus.out_f, prev_f);
        chk("hold_count", bus.out_count, prev_c);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_f_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got f=%b count=%0d, no result expected", bus.out_f, bus.out_count);
        end else begin
          chk("out_f", bus.out_f, exp_f_q.pop_front());
          chk("out_count", bus.out_count, exp_c_q.pop_front());
        end
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_f = bus.out_f;
      prev_c = bus.out_count;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_op = '0; bus.in_mode = 1'b0; bus.in_last = 1'b0;
    #12;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_f", bus.out_f, 0);
    chk("reset_out_count", bus.out_count, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    // pairwise, back-to-back
    send(4'b1010, 4'b0101, 3'd1, 1'b0, 1'b0);
    chk("pair_latency_valid", bus.out_valid, 1);
    send(4'b1100, 4'b1111, 3'd0, 1'b0, 1'b0);
    wait_drain();

    // accumulate OR burst: no output before the last beat
    send(4'b0001, 4'b0010, 3'd1, 1'b1, 1'b0);
    chk("acc_beat1_no_valid", bus.out_valid, 0);
    send(4'b0100, 4'b0000, 3'd5, 1'b0, 1'b0);
    chk("acc_beat2_no_valid", bus.out_valid, 0);
    send(4'b1000, 4'b0000, 3'd0, 1'b1, 1'b1);
    chk("acc_last_valid", bus.out_valid, 1);
    wait_drain();

    // backpressure
    ready_force = 1'b0;
    send(4'b1010, 4'b0101, 3'd1, 1'b0, 1'b0);
    fork
      send(4'b1100, 4'b1111, 3'd0, 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk); #3;
          chk("bp_in_ready", bus.in_ready, 0);
        end
        @(negedge clk) ready_force = 1'b1;
      end
    join
    chk("bp_new_result_valid", bus.out_valid, 1);
    wait_drain();

    // op latched on first beat
    send(4'b1111, 4'b1100, 3'd0, 1'b1, 1'b0);
    send(4'b0110, 4'b0000, 3'd1, 1'b1, 1'b1);
    wait_drain();

    // saturating count: 5-beat XOR burst
    send(4'b0001, 4'b0000, 3'd2, 1'b1, 1'b0);
    repeat (3) send(4'b0001, 4'b0000, 3'd2, 1'b1, 1'b0);
    send(4'b0001, 4'b0000, 3'd2, 1'b1, 1'b1);
    wait_drain();

    // reset mid-burst
    send(4'b0011, 4'b0101, 3'd0, 1'b1, 1'b0);
    send(4'b0110, 4'b0000, 3'd0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    in_burst = 0; operands.delete(); exp_f_q.delete(); exp_c_q.delete();
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    send(4'b0000, 4'b0000, 3'd4, 1'b1, 1'b1);
    wait_drain();

    // randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    send(W'($urandom), W'($urandom), 3'($urandom), 1'b1, 1'b1);
    rnd_ready = 1'b0;
    ready_force = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
